dcache_tag_arbiter: RTL and testbench
=====================================

Name: dcache_tag_arbiter

Overview:
- Sits between the data-cache requesters (miss handler, PTW, load unit, store unit) and the per-way tag/data/valid-dirty SRAM banks.
- Arbitrates requests with fixed priority and forwards the winner's address, write data, write enable and byte enables to the SRAMs.
- Returns the SRAM read data to all requesters.
- One cycle later, compares the winner's late-arriving physical tag against every way and produces a per-way hit vector.

Parameters:
- NR_PORTS, 4, number of requesters; port 0 has highest priority.
- ADDR_WIDTH, 12, index/offset address width.
- SET_ASSOC, 8, number of ways.
- TAG_WIDTH, 44, tag width.
- DATA_WIDTH, 128, cache-line data width.
- BE_WIDTH, 64, flat byte-enable vector width per request; passed through unmodified.
- LINE_W, derived = TAG_WIDTH+DATA_WIDTH+2; line packing MSB→LSB is {tag, data, valid, dirty}.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- req_i  in  NR_PORTS*SET_ASSOC  per-port way-select mask; port i is requesting if its mask is nonzero.
- gnt_o  out  NR_PORTS  one-hot (or zero) grant, combinational.
- addr_i  in  NR_PORTS*ADDR_WIDTH  per-port address.
- wdata_i  in  NR_PORTS*LINE_W  per-port write line.
- we_i  in  NR_PORTS  per-port write enable.
- be_i  in  NR_PORTS*BE_WIDTH  per-port byte enables.
- tag_i  in  NR_PORTS*TAG_WIDTH  per-port compare tag, valid the cycle after grant.
- rdata_o  out  SET_ASSOC*LINE_W  read lines to requesters.
- hit_way_o  out  SET_ASSOC  per-way hit.
- req_o  out  SET_ASSOC  way-select to SRAM.
- addr_o  out  ADDR_WIDTH  SRAM address.
- wdata_o  out  LINE_W  SRAM write line.
- we_o  out  1  SRAM write enable.
- be_o  out  BE_WIDTH  SRAM byte enables.
- rdata_i  in  SET_ASSOC*LINE_W  SRAM read lines (1-cycle read latency).

Behaviour:
- Arbitration (combinational): the winner is the lowest index i with req_i[i] != 0.
  - gnt_o[i]=1 for the winner only.
  - req_o=req_i[i]; addr_o/wdata_o/we_o/be_o = that port's fields.
- No request: gnt_o=0, req_o=0, addr_o=0, wdata_o=0, we_o=0, be_o=0.
- No fairness: a persistently requesting low-index port starves higher indices. This is intended.
- Grant is single-cycle, with no holding or locking. A requester that must repeat re-asserts its request.
- id register: id_d = winner index, or 0 when no request. Each cycle id_q <= id_d.
- Reset value of id_q is 0. Reset is asynchronous and active-high; it is applied immediately and affects only id_q.
- Tag select: sel_tag = tag_i[id_q], i.e. the tag of the port granted in the previous cycle.
- Hit: hit_way_o[j] = rdata_i[j].valid && (rdata_i[j].tag == sel_tag), evaluated combinationally.
  - Invalid ways never hit.
  - Multiple hits are not prevented by the block. A simulation-only check flags a non-onehot0 hit_way_o.
- rdata_o = rdata_i, passthrough with zero latency.
- During and right after reset, id_q=0, so hit_way_o compares tag_i[0]. Consumers ignore hit_way_o unless they were granted the previous cycle.
- Outputs during reset follow the combinational rules above; there are no other registered outputs.

Test Plan:
1. Priority: req_i[3]=0x01, req_i[1]=0x04, req_i[2]=0xFF.
   - Expect gnt_o=0b0010, req_o=0x04, addr_o=addr_i[1].
   - Drop port 1: gnt_o=0b0100, req_o=0xFF.
2. Idle: all req_i=0.
   - Expect gnt_o=0, req_o=0, we_o=0, addr_o=0.
3. Hit path: grant port 2 at cycle N. At N+1, drive tag_i[2]=0xABC, tag_i[0]=0x123, rdata_i way5 {tag=0xABC, valid=1}, other ways tag 0x123 with valid=0.
   - Expect hit_way_o=0x20.
4. Invalid line: same as case 3 but way5 valid=0.
   - Expect hit_way_o=0.
5. Reset: assert rst_i mid-stream after port 3 was granted.
   - id_q goes to 0 immediately, without waiting for a clock edge.
   - hit_way_o then compares tag_i[0].
6. Write passthrough: port 0 with we_i=1, be_i=all-ones, wdata_i pattern 0x5A…; port 3 also requesting.
   - Expect we_o=1, exact wdata_o/be_o match for port 0, gnt_o=0b0001.
   - rdata_o mirrors rdata_i the same cycle.

Source files
------------

// File: rtl/dcache_tag_arbiter.sv
// ----------------------------------------------------------------------------
// dcache_tag_arbiter
//
// Fixed-priority front end for the data-cache SRAM banks. Port 0 wins over
// every other port. The winner's way mask, address, write line, write enable
// and byte enables go straight to the SRAMs in the same cycle. The SRAM read
// lines come back one cycle later. At that point the tag that the previous
// winner supplies is compared against every way, producing a per-way hit
// vector.
//
// Line packing, MSB to LSB: {tag, data, valid, dirty}.
// ----------------------------------------------------------------------------
module dcache_tag_arbiter #(
    parameter int unsigned NR_PORTS   = 4,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned SET_ASSOC  = 8,
    parameter int unsigned TAG_WIDTH  = 44,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned BE_WIDTH   = 64,
    parameter int unsigned LINE_W     = TAG_WIDTH + DATA_WIDTH + 2
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    // requester side
    input  logic [NR_PORTS*SET_ASSOC-1:0]   req_i,
    output logic [NR_PORTS-1:0]             gnt_o,
    input  logic [NR_PORTS*ADDR_WIDTH-1:0]  addr_i,
    input  logic [NR_PORTS*LINE_W-1:0]      wdata_i,
    input  logic [NR_PORTS-1:0]             we_i,
    input  logic [NR_PORTS*BE_WIDTH-1:0]    be_i,
    input  logic [NR_PORTS*TAG_WIDTH-1:0]   tag_i,
    output logic [SET_ASSOC*LINE_W-1:0]     rdata_o,
    output logic [SET_ASSOC-1:0]            hit_way_o,
    // SRAM side
    output logic [SET_ASSOC-1:0]            req_o,
    output logic [ADDR_WIDTH-1:0]           addr_o,
    output logic [LINE_W-1:0]               wdata_o,
    output logic                            we_o,
    output logic [BE_WIDTH-1:0]             be_o,
    input  logic [SET_ASSOC*LINE_W-1:0]     rdata_i
);

    localparam int unsigned ID_WIDTH  = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
    // Field positions inside one packed line.
    localparam int unsigned VALID_BIT = 1;
    localparam int unsigned TAG_LSB   = DATA_WIDTH + 2;

    // ------------------------------------------------------------------------
    // Per-port views of the flat request buses
    // ------------------------------------------------------------------------
    logic [SET_ASSOC-1:0]  port_req   [NR_PORTS];
    logic [ADDR_WIDTH-1:0] port_addr  [NR_PORTS];
    logic [LINE_W-1:0]     port_wdata [NR_PORTS];
    logic [BE_WIDTH-1:0]   port_be    [NR_PORTS];
    logic [TAG_WIDTH-1:0]  port_tag   [NR_PORTS];
    logic [NR_PORTS-1:0]   port_active;

    for (genvar p = 0; p < NR_PORTS; p++) begin : g_port
        assign port_req[p]    = req_i[p*SET_ASSOC +: SET_ASSOC];
        assign port_addr[p]   = addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign port_wdata[p]  = wdata_i[p*LINE_W +: LINE_W];
        assign port_be[p]     = be_i[p*BE_WIDTH +: BE_WIDTH];
        assign port_tag[p]    = tag_i[p*TAG_WIDTH +: TAG_WIDTH];
        // A port is requesting whenever any of its way-select bits is set.
        assign port_active[p] = |port_req[p];
    end

    // ------------------------------------------------------------------------
    // Per-way views of the SRAM read lines (only the fields the compare needs)
    // ------------------------------------------------------------------------
    logic [TAG_WIDTH-1:0] way_tag   [SET_ASSOC];
    logic [SET_ASSOC-1:0] way_valid;

    for (genvar w = 0; w < SET_ASSOC; w++) begin : g_way
        assign way_tag[w]   = rdata_i[w*LINE_W + TAG_LSB +: TAG_WIDTH];
        assign way_valid[w] = rdata_i[w*LINE_W + VALID_BIT];
    end

    // ------------------------------------------------------------------------
    // Arbitration and SRAM request mux
    // ------------------------------------------------------------------------
    logic [ID_WIDTH-1:0] id_d;
    logic [ID_WIDTH-1:0] id_q;

    // Pick the lowest-index active port and forward its fields; idle drives zeros.
    always_comb begin
        // NOTE: every output gets a default before the loop, so no path
        // leaves a value unassigned and no latch is inferred.
        gnt_o   = '0;
        req_o   = '0;
        addr_o  = '0;
        wdata_o = '0;
        we_o    = 1'b0;
        be_o    = '0;
        id_d    = '0;
        // Walk from the highest index down. The last port that matches is the
        // lowest-index requester, which gives fixed priority with port 0 first.
        for (int i = NR_PORTS - 1; i >= 0; i--) begin
            if (port_active[i]) begin
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
                req_o    = port_req[i];
                addr_o   = port_addr[i];
                wdata_o  = port_wdata[i];
                we_o     = we_i[i];
                be_o     = port_be[i];
                id_d     = ID_WIDTH'(i);
            end
        end
    end

    // Remember which port won, so its late tag can be selected next cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop
        // samples pre-edge values regardless of the order of the blocks.
        if (rst_i) begin
            id_q <= '0;
        end else begin
            id_q <= id_d;
        end
    end

    // ------------------------------------------------------------------------
    // Tag compare
    // ------------------------------------------------------------------------
    logic [TAG_WIDTH-1:0] sel_tag;

    assign sel_tag = port_tag[id_q];

    // A way hits when it holds a valid line whose tag matches the previous winner's tag.
    always_comb begin
        hit_way_o = '0;
        for (int j = 0; j < SET_ASSOC; j++) begin
            hit_way_o[j] = way_valid[j] && (way_tag[j] == sel_tag);
        end
    end

    // Read lines are shared by all requesters with no extra latency.
    assign rdata_o = rdata_i;

`ifndef SYNTHESIS
    // This block does not prevent duplicate tags across ways. Flag them here.
    hit_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(hit_way_o))
        else $error("dcache_tag_arbiter: more than one way hit (hit_way_o=%b)", hit_way_o);
`endif

endmodule

// File: tb/tb_dcache_tag_arbiter.sv
// ----------------------------------------------------------------------------
// Testbench for dcache_tag_arbiter.
// Directed scenarios and a randomized run are checked against a small
// behavioural model. The model finds the first requesting port, tracks the
// previous winner, and applies the valid-and-tag-equal hit rule per way.
// ----------------------------------------------------------------------------
module tb_dcache_tag_arbiter;

    localparam int NP = 4;
    localparam int AW = 12;
    localparam int SA = 8;
    localparam int TW = 44;
    localparam int DW = 128;
    localparam int BW = 64;
    localparam int LW = TW + DW + 2;

    logic               clk;
    logic               rst_i;
    logic [NP*SA-1:0]   req_i;
    logic [NP-1:0]      gnt_o;
    logic [NP*AW-1:0]   addr_i;
    logic [NP*LW-1:0]   wdata_i;
    logic [NP-1:0]      we_i;
    logic [NP*BW-1:0]   be_i;
    logic [NP*TW-1:0]   tag_i;
    logic [SA*LW-1:0]   rdata_o;
    logic [SA-1:0]      hit_way_o;
    logic [SA-1:0]      req_o;
    logic [AW-1:0]      addr_o;
    logic [LW-1:0]      wdata_o;
    logic               we_o;
    logic [BW-1:0]      be_o;
    logic [SA*LW-1:0]   rdata_i;

    // Bench-side stimulus, one entry per port or per way.
    logic [SA-1:0] req_a   [NP];
    logic [AW-1:0] addr_a  [NP];
    logic [LW-1:0] wdata_a [NP];
    logic [BW-1:0] be_a    [NP];
    logic [TW-1:0] tag_a   [NP];
    logic [LW-1:0] rline_a [SA];

    int checks = 0;
    int errors = 0;
    int last_win = 0;   // model of the previously granted port

    for (genvar p = 0; p < NP; p++) begin : g_pack_port
        assign req_i[p*SA +: SA]   = req_a[p];
        assign addr_i[p*AW +: AW]  = addr_a[p];
        assign wdata_i[p*LW +: LW] = wdata_a[p];
        assign be_i[p*BW +: BW]    = be_a[p];
        assign tag_i[p*TW +: TW]   = tag_a[p];
    end
    for (genvar w = 0; w < SA; w++) begin : g_pack_way
        assign rdata_i[w*LW +: LW] = rline_a[w];
    end

    dcache_tag_arbiter #(
        .NR_PORTS  (NP),
        .ADDR_WIDTH(AW),
        .SET_ASSOC (SA),
        .TAG_WIDTH (TW),
        .DATA_WIDTH(DW),
        .BE_WIDTH  (BW)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .req_i    (req_i),
        .gnt_o    (gnt_o),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .we_i     (we_i),
        .be_i     (be_i),
        .tag_i    (tag_i),
        .rdata_o  (rdata_o),
        .hit_way_o(hit_way_o),
        .req_o    (req_o),
        .addr_o   (addr_o),
        .wdata_o  (wdata_o),
        .we_o     (we_o),
        .be_o     (be_o),
        .rdata_i  (rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- model
    function automatic int ref_winner();
        for (int i = 0; i < NP; i++) begin
            if (req_a[i] != '0) return i;
        end
        return -1;
    endfunction

    function automatic logic [SA-1:0] ref_hit(input int id);
        logic [SA-1:0] h;
        h = '0;
        for (int j = 0; j < SA; j++) begin
            h[j] = rline_a[j][1] && (rline_a[j][LW-1 -: TW] == tag_a[id]);
        end
        return h;
    endfunction

    function automatic logic [SA*LW-1:0] ref_rdata();
        logic [SA*LW-1:0] r;
        for (int j = 0; j < SA; j++) r[j*LW +: LW] = rline_a[j];
        return r;
    endfunction

    // ---------------------------------------------------------------- helpers
    function automatic logic [LW-1:0] mk_line(input logic [TW-1:0] t, input logic [DW-1:0] d,
                                              input logic v, input logic dy);
        return {t, d, v, dy};
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        logic [31:0]   w;
        w = '0;
        for (int k = 0; k < LW; k++) begin
            if (k % 32 == 0) w = $urandom;
            r[k] = w[k % 32];
        end
        return r;
    endfunction

    function automatic logic [TW-1:0] rand_tag();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[TW-1:0];
    endfunction

    task automatic clear_inputs();
        for (int i = 0; i < NP; i++) begin
            req_a[i]   = '0;
            addr_a[i]  = '0;
            wdata_a[i] = '0;
            be_a[i]    = '0;
            tag_a[i]   = '0;
        end
        for (int j = 0; j < SA; j++) rline_a[j] = '0;
        we_i = '0;
    endtask

    // One clock: update the previous-winner model at the edge, return at negedge.
    task automatic cycle();
        int w;
        @(posedge clk);
        w = ref_winner();
        if (rst_i) last_win = 0;
        else       last_win = (w < 0) ? 0 : w;
        @(negedge clk);
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        rst_i = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (gnt_o !== '0) begin errors++; $display("FAIL reset_gnt: got %b expected 0", gnt_o); end
        checks++;
        if (req_o !== '0) begin errors++; $display("FAIL reset_req: got %h expected 0", req_o); end
        checks++;
        if (hit_way_o !== '0) begin errors++; $display("FAIL reset_hit: got %h expected 0", hit_way_o); end
        rst_i = 1'b0;
        last_win = 0;
        cycle();
    endtask

    task automatic test_priority();
        clear_inputs();
        req_a[3] = 8'h01; addr_a[3] = 12'h0A3;
        req_a[1] = 8'h04; addr_a[1] = 12'h3C1;
        req_a[2] = 8'hFF; addr_a[2] = 12'h7E2;
        #1;
        checks++;
        if (gnt_o !== 4'b0010) begin errors++; $display("FAIL prio_gnt: got %b expected 0010", gnt_o); end
        checks++;
        if (req_o !== 8'h04) begin errors++; $display("FAIL prio_req: got %h expected 04", req_o); end
        checks++;
        if (addr_o !== 12'h3C1) begin errors++; $display("FAIL prio_addr: got %h expected 3c1", addr_o); end
        req_a[1] = '0;
        #1;
        checks++;
        if (gnt_o !== 4'b0100) begin errors++; $display("FAIL prio_drop_gnt: got %b expected 0100", gnt_o); end
        checks++;
        if (req_o !== 8'hFF) begin errors++; $display("FAIL prio_drop_req: got %h expected ff", req_o); end
        checks++;
        if (addr_o !== 12'h7E2) begin errors++; $display("FAIL prio_drop_addr: got %h expected 7e2", addr_o); end
        cycle();
    endtask

    task automatic test_idle();
        clear_inputs();
        // Non-request fields are busy, so a leak through the mux would show.
        for (int i = 0; i < NP; i++) begin
            addr_a[i]  = 12'hFFF;
            wdata_a[i] = '1;
            be_a[i]    = '1;
        end
        we_i = '1;
        #1;
        checks++;
        if (gnt_o !== '0) begin errors++; $display("FAIL idle_gnt: got %b expected 0", gnt_o); end
        checks++;
        if (req_o !== '0) begin errors++; $display("FAIL idle_req: got %h expected 0", req_o); end
        checks++;
        if (we_o !== 1'b0) begin errors++; $display("FAIL idle_we: got %b expected 0", we_o); end
        checks++;
        if (addr_o !== '0) begin errors++; $display("FAIL idle_addr: got %h expected 0", addr_o); end
        checks++;
        if (wdata_o !== '0 || be_o !== '0) begin
            errors++; $display("FAIL idle_wdata_be: got %h / %h expected 0 / 0", wdata_o, be_o);
        end
        cycle();
    endtask

    task automatic test_hit(input logic way5_valid, input string name);
        clear_inputs();
        req_a[2] = 8'h20;
        cycle();                       // port 2 granted at N
        req_a[2] = '0;
        tag_a[2] = 44'hABC;
        tag_a[0] = 44'h123;
        for (int j = 0; j < SA; j++) rline_a[j] = mk_line(44'h123, {4{$urandom}}, 1'b0, 1'b1);
        rline_a[5] = mk_line(44'hABC, {4{$urandom}}, way5_valid, 1'b0);
        #1;
        checks++;
        if (hit_way_o !== (way5_valid ? 8'h20 : 8'h00)) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, hit_way_o, way5_valid ? 8'h20 : 8'h00);
        end
        cycle();
        clear_inputs();
    endtask

    task automatic test_reset_midstream();
        clear_inputs();
        req_a[3] = 8'h10;
        cycle();                       // port 3 granted
        tag_a[3] = 44'h0DE_ADBE_EF01;
        tag_a[0] = 44'h000_0055_AA55;
        for (int j = 0; j < SA; j++) rline_a[j] = mk_line(44'h777, '0, 1'b1, 1'b0);
        rline_a[2] = mk_line(tag_a[3], {4{$urandom}}, 1'b1, 1'b0);
        rline_a[6] = mk_line(tag_a[0], {4{$urandom}}, 1'b1, 1'b1);
        #1;
        checks++;
        if (hit_way_o !== 8'h04) begin errors++; $display("FAIL mid_pre_reset_hit: got %h expected 04", hit_way_o); end
        #1 rst_i = 1'b1;               // no clock edge before the next check
        #1;
        checks++;
        if (hit_way_o !== 8'h40) begin errors++; $display("FAIL mid_async_reset_hit: got %h expected 40", hit_way_o); end
        checks++;
        if (gnt_o !== 4'b1000) begin errors++; $display("FAIL mid_reset_gnt: got %b expected 1000", gnt_o); end
        cycle();
        checks++;
        if (hit_way_o !== 8'h40) begin errors++; $display("FAIL mid_reset_held_hit: got %h expected 40", hit_way_o); end
        clear_inputs();
        rst_i = 1'b0;
        last_win = 0;
        cycle();
    endtask

    task automatic test_write_passthrough();
        logic [LW-1:0] pat;
        logic [7:0]    byte_pat;
        byte_pat = 8'h5A;
        for (int k = 0; k < LW; k++) pat[k] = byte_pat[k % 8];
        clear_inputs();
        req_a[0] = 8'h81; we_i[0] = 1'b1; be_a[0] = '1; wdata_a[0] = pat; addr_a[0] = 12'h5A5;
        req_a[3] = 8'hFF; we_i[3] = 1'b0; be_a[3] = '0; wdata_a[3] = rand_line(); addr_a[3] = 12'h123;
        for (int j = 0; j < SA; j++) rline_a[j] = mk_line(rand_tag() | 44'h1, {4{$urandom}}, 1'b0, $urandom_range(0, 1) == 1);
        #1;
        checks++;
        if (gnt_o !== 4'b0001) begin errors++; $display("FAIL wr_gnt: got %b expected 0001", gnt_o); end
        checks++;
        if (we_o !== 1'b1) begin errors++; $display("FAIL wr_we: got %b expected 1", we_o); end
        checks++;
        if (wdata_o !== pat) begin errors++; $display("FAIL wr_wdata: got %h expected %h", wdata_o, pat); end
        checks++;
        if (be_o !== {BW{1'b1}}) begin errors++; $display("FAIL wr_be: got %h expected all ones", be_o); end
        checks++;
        if (addr_o !== 12'h5A5 || req_o !== 8'h81) begin
            errors++; $display("FAIL wr_addr_req: got %h/%h expected 5a5/81", addr_o, req_o);
        end
        checks++;
        if (rdata_o !== ref_rdata()) begin errors++; $display("FAIL wr_rdata: got %h expected %h", rdata_o, ref_rdata()); end
        cycle();
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        // Port 0 keeps requesting and port 3 starves; the grant does not lock.
        for (int c = 0; c < 3; c++) begin
            req_a[0] = 8'h01 << c; addr_a[0] = AW'(12'h100 + c);
            req_a[3] = 8'h80;
            #1;
            checks++;
            if (gnt_o !== 4'b0001 || addr_o !== AW'(12'h100 + c)) begin
                errors++; $display("FAIL b2b_starve: got %b/%h expected 0001/%h", gnt_o, addr_o, AW'(12'h100 + c));
            end
            cycle();
        end
        req_a[0] = '0;
        #1;
        checks++;
        if (gnt_o !== 4'b1000 || req_o !== 8'h80) begin
            errors++; $display("FAIL b2b_release: got %b/%h expected 1000/80", gnt_o, req_o);
        end
        cycle();
        clear_inputs();
    endtask

    task automatic test_random(input int iters);
        int            w;
        int            hw;
        logic [SA-1:0] e_gnt_req;
        for (int n = 0; n < iters; n++) begin
            for (int i = 0; i < NP; i++) begin
                req_a[i]   = ($urandom_range(0, 1) == 1) ? SA'($urandom) : '0;
                addr_a[i]  = AW'($urandom);
                wdata_a[i] = rand_line();
                be_a[i]    = {$urandom, $urandom};
                tag_a[i]   = rand_tag();
                we_i[i]    = $urandom_range(0, 1) == 1;
            end
            // At most one way may carry the previous winner's tag.
            hw = $urandom_range(0, SA - 1);
            for (int j = 0; j < SA; j++) begin
                logic [TW-1:0] t;
                t = rand_tag();
                if (t == tag_a[last_win]) t = t ^ 44'h1;
                if (j == hw && $urandom_range(0, 3) != 0) t = tag_a[last_win];
                rline_a[j] = mk_line(t, {4{$urandom}}, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            end
            #1;
            w = ref_winner();
            e_gnt_req = (w < 0) ? '0 : req_a[w];
            checks++;
            if (gnt_o !== ((w < 0) ? 4'b0 : NP'(1 << w))) begin
                errors++; $display("FAIL rand_gnt[%0d]: got %b expected winner %0d", n, gnt_o, w);
            end
            checks++;
            if (req_o !== e_gnt_req) begin errors++; $display("FAIL rand_req[%0d]: got %h expected %h", n, req_o, e_gnt_req); end
            checks++;
            if (addr_o !== ((w < 0) ? '0 : addr_a[w]) || we_o !== ((w < 0) ? 1'b0 : we_i[w])) begin
                errors++; $display("FAIL rand_addr_we[%0d]: got %h/%b winner %0d", n, addr_o, we_o, w);
            end
            checks++;
            if (wdata_o !== ((w < 0) ? '0 : wdata_a[w]) || be_o !== ((w < 0) ? '0 : be_a[w])) begin
                errors++; $display("FAIL rand_wdata_be[%0d]: got %h/%h winner %0d", n, wdata_o, be_o, w);
            end
            checks++;
            if (hit_way_o !== ref_hit(last_win)) begin
                errors++; $display("FAIL rand_hit[%0d]: got %h expected %h", n, hit_way_o, ref_hit(last_win));
            end
            checks++;
            if (rdata_o !== ref_rdata()) begin errors++; $display("FAIL rand_rdata[%0d]: got %h", n, rdata_o); end
            cycle();
        end
        clear_inputs();
    endtask

    initial begin
        rst_i = 1'b1;
        clear_inputs();
        test_reset();
        test_priority();
        test_idle();
        test_hit(1'b1, "hit_way5");
        test_hit(1'b0, "hit_invalid_way5");
        test_reset_midstream();
        test_write_passthrough();
        test_back_to_back();
        test_random(300);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
